// File: rtl/cpu_def.sv
// Shared core definitions: writeback-select and forwarding-select encodings,
// plus the MDU handshake state type used by the hazard controller.
package cpu_def;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_LSU = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_CSR = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // M is the younger producer, so it shadows W when both match.
    function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
        logic [1:0] sel;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register fields and stage
// status in, stage control, operand selects and perf counters out.
interface hazard_ctrl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    logic [AW-1:0]    rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE;
    logic             rs1_useD, rs2_useD, rs1_useE, rs2_useE;
    logic [AW-1:0]    rd_addrE, rd_addrM, rd_addrW;
    logic             rd_wr_enE, rd_wr_enM, rd_wr_enW;
    logic [1:0]       wb_selE;
    logic             br_selE;
    logic             mdu_reqE;
    logic             mdu_done;
    logic             lsu_ready;
    logic             cnt_clr;
    logic             mdu_go;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushM;
    logic [1:0]       fwa_sel, fwb_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE,
        output rs1_useD, rs2_useD, rs1_useE, rs2_useE,
        output rd_addrE, rd_addrM, rd_addrW, rd_wr_enE, rd_wr_enM, rd_wr_enW,
        output wb_selE, br_selE, mdu_reqE, mdu_done, lsu_ready, cnt_clr,
        input  mdu_go, stallF, stallD, stallE, stallM, flushD, flushE, flushM,
        input  fwa_sel, fwb_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE,
        input  rs1_useD, rs2_useD, rs1_useE, rs2_useE,
        input  rd_addrE, rd_addrM, rd_addrW, rd_wr_enE, rd_wr_enM, rd_wr_enW,
        input  wb_selE, br_selE, mdu_reqE, mdu_done, lsu_ready, cnt_clr,
        output mdu_go, stallF, stallD, stallE, stallM, flushD, flushE, flushM,
        output fwa_sel, fwb_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_chk.sv
// Protocol checks for the hazard controller's MDU handshake.
module hazard_ctrl_chk
    import cpu_def::*;
(
    input logic       clk,
    input logic       rst,
    input mdu_state_e state_i,
    input logic       mdu_req_i
);
    // An MDU op may not leave E while its result is still outstanding.
    property p_req_held_in_busy;
        @(posedge clk) disable iff (rst) (state_i == MDU_BUSY) |-> mdu_req_i;
    endproperty

    a_req_held_in_busy: assert property (p_req_held_in_busy);
endmodule

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; a clear in the same cycle as an event wins.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, stall/flush
// arbitration, MDU start/done tracking and saturating stall/flush counters.
module hazard_ctrl
    import cpu_def::*;
#(
    parameter int AW        = 5,
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    mdu_state_e state_q;
    logic       hit1m_s, hit1w_s, hit2m_s, hit2w_s;
    logic       dep_e_s, dep_m_s, dep_w_s;
    logic       lu_s, ri_s, freeze_s, ms_s, go_s, flush_ev_s;
    logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic       flush_d_s, flush_e_s, flush_m_s;
    logic [1:0] fwa_s, fwb_s;

    function automatic logic src_hit(input logic use_v, input logic [AW-1:0] rs,
                                     input logic [AW-1:0] rd, input logic wen);
        return use_v && (rs != {AW{1'b0}}) && (rs == rd) && wen;
    endfunction

    assign hit1m_s = src_hit(hz.rs1_useE, hz.rs1_addrE, hz.rd_addrM, hz.rd_wr_enM);
    assign hit1w_s = src_hit(hz.rs1_useE, hz.rs1_addrE, hz.rd_addrW, hz.rd_wr_enW);
    assign hit2m_s = src_hit(hz.rs2_useE, hz.rs2_addrE, hz.rd_addrM, hz.rd_wr_enM);
    assign hit2w_s = src_hit(hz.rs2_useE, hz.rs2_addrE, hz.rd_addrW, hz.rd_wr_enW);

    // Operand bypass selects for the E stage.
    always_comb begin
        fwa_s = FWD_RF;
        fwb_s = FWD_RF;
        if (FWD_EN) begin
            fwa_s = fwd_pick(hit1m_s, hit1w_s);
            fwb_s = fwd_pick(hit2m_s, hit2w_s);
        end else begin
            fwa_s = FWD_RF;
            fwb_s = FWD_RF;
        end
    end

    assign dep_e_s = src_hit(hz.rs1_useD, hz.rs1_addrD, hz.rd_addrE, hz.rd_wr_enE)
                   | src_hit(hz.rs2_useD, hz.rs2_addrD, hz.rd_addrE, hz.rd_wr_enE);
    assign dep_m_s = src_hit(hz.rs1_useD, hz.rs1_addrD, hz.rd_addrM, hz.rd_wr_enM)
                   | src_hit(hz.rs2_useD, hz.rs2_addrD, hz.rd_addrM, hz.rd_wr_enM);
    assign dep_w_s = src_hit(hz.rs1_useD, hz.rs1_addrD, hz.rd_addrW, hz.rd_wr_enW)
                   | src_hit(hz.rs2_useD, hz.rs2_addrD, hz.rd_addrW, hz.rd_wr_enW);

    assign lu_s = (hz.wb_selE == WB_SEL_LSU) && (hz.rd_addrE != {AW{1'b0}}) && dep_e_s;
    assign ri_s = !FWD_EN && (dep_e_s || dep_m_s || (!RF_BYPASS && dep_w_s));

    assign freeze_s   = !hz.lsu_ready;
    assign go_s       = (state_q == MDU_IDLE) && hz.mdu_reqE && hz.lsu_ready && !hz.mdu_done;
    assign ms_s       = ((state_q == MDU_IDLE) || (state_q == MDU_BUSY))
                        && hz.mdu_reqE && !hz.mdu_done;
    assign flush_ev_s = hz.br_selE && !freeze_s && !ms_s;

    // MDU handshake tracker; DONE parks a finished result behind a memory freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (go_s) state_q <= MDU_BUSY;
                    else      state_q <= MDU_IDLE;
                end
                MDU_BUSY: begin
                    if (hz.mdu_done && hz.lsu_ready) state_q <= MDU_IDLE;
                    else if (hz.mdu_done)            state_q <= MDU_DONE;
                    else                             state_q <= MDU_BUSY;
                end
                MDU_DONE: begin
                    if (hz.lsu_ready) state_q <= MDU_IDLE;
                    else              state_q <= MDU_DONE;
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    // Stall/flush arbitration: freeze, MDU, branch, then data hazards.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_m_s = 1'b0;
        if (freeze_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
        end else if (ms_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            flush_m_s = 1'b1;
        end else if (hz.br_selE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (lu_s || ri_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    assign hz.mdu_go  = go_s;
    assign hz.stallF  = stall_f_s;
    assign hz.stallD  = stall_d_s;
    assign hz.stallE  = stall_e_s;
    assign hz.stallM  = stall_m_s;
    assign hz.flushD  = flush_d_s;
    assign hz.flushE  = flush_e_s;
    assign hz.flushM  = flush_m_s;
    assign hz.fwa_sel = fwa_s;
    assign hz.fwb_sel = fwb_s;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_f_s),
        .clr_i (hz.cnt_clr),
        .cnt_o (hz.stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_ev_s),
        .clr_i (hz.cnt_clr),
        .cnt_o (hz.flush_cnt)
    );

    hazard_ctrl_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .state_i   (state_q),
        .mdu_req_i (hz.mdu_reqE)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one forwarding/bypass instance and one
// interlock instance with a 4-bit counter, both checked against a rule model.
module tb_hazard_ctrl;
    import cpu_def::*;

    typedef struct packed {
        logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE;
        logic       rs1_useD, rs2_useD, rs1_useE, rs2_useE;
        logic [4:0] rd_addrE, rd_addrM, rd_addrW;
        logic       rd_wr_enE, rd_wr_enM, rd_wr_enW;
        logic [1:0] wb_selE;
        logic       br_selE, mdu_reqE, mdu_done, lsu_ready, cnt_clr;
    } in_t;

    typedef struct packed {
        logic go, sf, sd, se, sm, fd, fe, fm;
        logic [1:0] fa, fb;
    } o_t;

    localparam int unsigned MAX_A = 32'hFFFF_FFFF;
    localparam int unsigned MAX_B = 32'd15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  stim;
    int   checks = 0;
    int   errors = 0;
    bit   m_out = 1'b0;
    bit   m_parked = 1'b0;
    int unsigned m_sc_a = 0, m_fc_a = 0, m_sc_b = 0, m_fc_b = 0;
    o_t   exp_a, exp_b, out_a, out_b;
    bit   exp_fl;
    int   go_n, st_n;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.AW(5), .CNT_W(32)) ifa ();
    hazard_ctrl_if #(.AW(5), .CNT_W(4))  ifb ();

    hazard_ctrl #(.AW(5), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa));
    hazard_ctrl #(.AW(5), .FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb));

    assign ifa.rs1_addrD = stim.rs1_addrD;  assign ifb.rs1_addrD = stim.rs1_addrD;
    assign ifa.rs2_addrD = stim.rs2_addrD;  assign ifb.rs2_addrD = stim.rs2_addrD;
    assign ifa.rs1_addrE = stim.rs1_addrE;  assign ifb.rs1_addrE = stim.rs1_addrE;
    assign ifa.rs2_addrE = stim.rs2_addrE;  assign ifb.rs2_addrE = stim.rs2_addrE;
    assign ifa.rs1_useD  = stim.rs1_useD;   assign ifb.rs1_useD  = stim.rs1_useD;
    assign ifa.rs2_useD  = stim.rs2_useD;   assign ifb.rs2_useD  = stim.rs2_useD;
    assign ifa.rs1_useE  = stim.rs1_useE;   assign ifb.rs1_useE  = stim.rs1_useE;
    assign ifa.rs2_useE  = stim.rs2_useE;   assign ifb.rs2_useE  = stim.rs2_useE;
    assign ifa.rd_addrE  = stim.rd_addrE;   assign ifb.rd_addrE  = stim.rd_addrE;
    assign ifa.rd_addrM  = stim.rd_addrM;   assign ifb.rd_addrM  = stim.rd_addrM;
    assign ifa.rd_addrW  = stim.rd_addrW;   assign ifb.rd_addrW  = stim.rd_addrW;
    assign ifa.rd_wr_enE = stim.rd_wr_enE;  assign ifb.rd_wr_enE = stim.rd_wr_enE;
    assign ifa.rd_wr_enM = stim.rd_wr_enM;  assign ifb.rd_wr_enM = stim.rd_wr_enM;
    assign ifa.rd_wr_enW = stim.rd_wr_enW;  assign ifb.rd_wr_enW = stim.rd_wr_enW;
    assign ifa.wb_selE   = stim.wb_selE;    assign ifb.wb_selE   = stim.wb_selE;
    assign ifa.br_selE   = stim.br_selE;    assign ifb.br_selE   = stim.br_selE;
    assign ifa.mdu_reqE  = stim.mdu_reqE;   assign ifb.mdu_reqE  = stim.mdu_reqE;
    assign ifa.mdu_done  = stim.mdu_done;   assign ifb.mdu_done  = stim.mdu_done;
    assign ifa.lsu_ready = stim.lsu_ready;  assign ifb.lsu_ready = stim.lsu_ready;
    assign ifa.cnt_clr   = stim.cnt_clr;    assign ifb.cnt_clr   = stim.cnt_clr;

    assign out_a = {ifa.mdu_go, ifa.stallF, ifa.stallD, ifa.stallE, ifa.stallM,
                    ifa.flushD, ifa.flushE, ifa.flushM, ifa.fwa_sel, ifa.fwb_sel};
    assign out_b = {ifb.mdu_go, ifb.stallF, ifb.stallD, ifb.stallE, ifb.stallM,
                    ifb.flushD, ifb.flushE, ifb.flushM, ifb.fwa_sel, ifb.fwb_sel};

    // Does the D instruction read a register being produced as (rd, we)?
    function automatic bit dep_on(input logic [4:0] rd, input logic we);
        return we && (rd != 5'd0) &&
               ((stim.rs1_useD && stim.rs1_addrD == rd) || (stim.rs2_useD && stim.rs2_addrD == rd));
    endfunction

    function automatic logic [1:0] src_of(input logic use_e, input logic [4:0] rs);
        if (!use_e || rs == 5'd0) return 2'd0;
        if (stim.rd_wr_enM && stim.rd_addrM == rs) return 2'd1;
        if (stim.rd_wr_enW && stim.rd_addrW == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit mdu_stall();
        return stim.mdu_reqE && !stim.mdu_done && !m_parked;
    endfunction

    function automatic o_t model_out(input bit fwd, input bit byp);
        o_t o;
        bit lu, ri;
        o    = '0;
        o.go = stim.mdu_reqE && stim.lsu_ready && !stim.mdu_done && !m_out && !m_parked;
        lu   = (stim.wb_selE == WB_SEL_LSU) && (stim.rd_addrE != 5'd0) &&
               dep_on(stim.rd_addrE, stim.rd_wr_enE);
        ri   = !fwd && (dep_on(stim.rd_addrE, stim.rd_wr_enE) || dep_on(stim.rd_addrM, stim.rd_wr_enM) ||
                        (!byp && dep_on(stim.rd_addrW, stim.rd_wr_enW)));
        if (!stim.lsu_ready) begin
            o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.sm = 1'b1;
        end else if (mdu_stall()) begin
            o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.fm = 1'b1;
        end else if (stim.br_selE) begin
            o.fd = 1'b1; o.fe = 1'b1;
        end else if (lu || ri) begin
            o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
        end
        if (fwd) begin
            o.fa = src_of(stim.rs1_useE, stim.rs1_addrE);
            o.fb = src_of(stim.rs2_useE, stim.rs2_addrE);
        end
        return o;
    endfunction

    always_comb begin
        exp_a  = model_out(1'b1, 1'b1);
        exp_b  = model_out(1'b0, 1'b0);
        exp_fl = stim.br_selE && stim.lsu_ready && !mdu_stall();
    end

    function automatic int unsigned bump(input int unsigned c, input bit inc,
                                         input bit clr, input int unsigned mx);
        if (clr) return 0;
        if (inc && c < mx) return c + 1;
        return c;
    endfunction

    // Model state: MDU op outstanding / result parked behind a freeze, counters.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out <= 1'b0; m_parked <= 1'b0;
            m_sc_a <= 0; m_fc_a <= 0; m_sc_b <= 0; m_fc_b <= 0;
        end else begin
            if (exp_a.go) begin
                m_out <= 1'b1;
            end else if (m_out && stim.mdu_done) begin
                m_out    <= 1'b0;
                m_parked <= !stim.lsu_ready;
            end else if (m_parked && stim.lsu_ready) begin
                m_parked <= 1'b0;
            end
            m_sc_a <= bump(m_sc_a, exp_a.sf, stim.cnt_clr, MAX_A);
            m_fc_a <= bump(m_fc_a, exp_fl,   stim.cnt_clr, MAX_A);
            m_sc_b <= bump(m_sc_b, exp_b.sf, stim.cnt_clr, MAX_B);
            m_fc_b <= bump(m_fc_b, exp_fl,   stim.cnt_clr, MAX_B);
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp("outs_A", {20'd0, out_a}, {20'd0, exp_a});
        cmp("outs_B", {20'd0, out_b}, {20'd0, exp_b});
        cmp("stall_cnt_A", ifa.stall_cnt, m_sc_a);
        cmp("flush_cnt_A", ifa.flush_cnt, m_fc_a);
        cmp("stall_cnt_B", {28'd0, ifb.stall_cnt}, m_sc_b);
        cmp("flush_cnt_B", {28'd0, ifb.flush_cnt}, m_fc_b);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neutral();
        stim           = '0;
        stim.lsu_ready = 1'b1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        neutral();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        cmp("rst_stall_cnt", ifa.stall_cnt, 32'd0);
        cmp("rst_flush_cnt", {28'd0, ifb.flush_cnt}, 32'd0);
        cmp("rst_go", {31'd0, ifa.mdu_go}, 32'd0);

        // Forwarding: x5 produced in both M and W.
        cyc(); neutral();
        stim.rs1_useE = 1'b1; stim.rs1_addrE = 5'd5; stim.rs2_useE = 1'b1; stim.rs2_addrE = 5'd5;
        stim.rd_addrM = 5'd5; stim.rd_wr_enM = 1'b1; stim.rd_addrW = 5'd5; stim.rd_wr_enW = 1'b1;
        settle();
        cmp("fwa_M_prio", {30'd0, ifa.fwa_sel}, 32'd1);
        cmp("fwb_M_prio", {30'd0, ifa.fwb_sel}, 32'd1);
        cmp("fwa_nofwd", {30'd0, ifb.fwa_sel}, 32'd0);
        cyc(); stim.rd_wr_enM = 1'b0; settle();
        cmp("fwa_W", {30'd0, ifa.fwa_sel}, 32'd2);
        cyc(); stim.rs2_addrE = 5'd9; settle();
        cmp("fwb_none", {30'd0, ifa.fwb_sel}, 32'd0);
        cyc(); neutral();
        stim.rs1_useE = 1'b1; stim.rs1_addrE = 5'd0; stim.rd_addrM = 5'd0; stim.rd_wr_enM = 1'b1;
        stim.rd_addrW = 5'd0; stim.rd_wr_enW = 1'b1;
        settle();
        cmp("fwa_x0", {30'd0, ifa.fwa_sel}, 32'd0);

        // Load-use: lw x7 in E, D reads x7 through rs2.
        cyc(); neutral(); stim.cnt_clr = 1'b1;
        cyc(); neutral();
        stim.wb_selE = WB_SEL_LSU; stim.rd_addrE = 5'd7; stim.rd_wr_enE = 1'b1;
        stim.rs2_addrD = 5'd7; stim.rs2_useD = 1'b1;
        settle();
        cmp("lu_stallF", {31'd0, ifa.stallF}, 32'd1);
        cmp("lu_flushE", {31'd0, ifa.flushE}, 32'd1);
        cmp("lu_stallE", {31'd0, ifa.stallE}, 32'd0);
        cyc(); neutral();
        stim.rd_addrM = 5'd7; stim.rd_wr_enM = 1'b1; stim.rs2_addrD = 5'd7; stim.rs2_useD = 1'b1;
        settle();
        cmp("lu_one_bubble", {31'd0, ifa.stallF}, 32'd0);
        cyc(); neutral(); settle();
        cmp("lu_stall_cnt", ifa.stall_cnt, 32'd1);
        stim.wb_selE = WB_SEL_LSU; stim.rd_addrE = 5'd7; stim.rd_wr_enE = 1'b1;
        stim.rs2_addrD = 5'd7; stim.rs2_useD = 1'b0;
        settle();
        cmp("lu_unused_src", {31'd0, ifa.stallF}, 32'd0);

        // MDU op of 4 cycles.
        go_n = 0; st_n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); neutral(); stim.mdu_reqE = 1'b1; stim.mdu_done = (i == 4); settle();
            go_n += int'(ifa.mdu_go);
            st_n += int'(ifa.stallE);
        end
        cmp("mdu_go_pulses", go_n, 32'd1);
        cmp("mdu_stallE_cycles", st_n, 32'd4);
        // Same op, memory not ready when the result arrives.
        for (int i = 0; i < 5; i++) begin
            cyc(); neutral(); stim.mdu_reqE = 1'b1; stim.mdu_done = (i == 4);
            stim.lsu_ready = (i != 4); settle();
            if (i == 0) cmp("mdu_go_from_idle", {31'd0, ifa.mdu_go}, 32'd1);
        end
        cyc(); neutral(); stim.mdu_reqE = 1'b1; stim.lsu_ready = 1'b0; settle();
        cmp("mdu_done_frozen", {31'd0, ifa.stallM}, 32'd1);
        cyc(); neutral(); stim.mdu_reqE = 1'b1; settle();
        cmp("mdu_done_no_go", {31'd0, ifa.mdu_go}, 32'd0);
        cmp("mdu_done_no_stall", {31'd0, ifa.stallE}, 32'd0);
        cyc(); neutral(); stim.mdu_reqE = 1'b1; settle();
        cmp("mdu_back_idle", {31'd0, ifa.mdu_go}, 32'd1);
        cyc(); neutral(); stim.mdu_reqE = 1'b1; stim.mdu_done = 1'b1;
        cyc(); neutral(); stim.mdu_reqE = 1'b1; stim.mdu_done = 1'b1; settle();
        cmp("mdu_single_go", {31'd0, ifa.mdu_go}, 32'd0);
        cmp("mdu_single_stall", {31'd0, ifa.stallE}, 32'd0);
        // Reset while BUSY returns the tracker to IDLE.
        cyc(); neutral(); stim.mdu_reqE = 1'b1;
        cyc(); neutral(); stim.mdu_reqE = 1'b1; settle();
        cmp("mdu_busy_no_go", {31'd0, ifa.mdu_go}, 32'd0);
        rst = 1'b1; settle();
        cmp("mdu_rst_idle", {31'd0, ifa.mdu_go}, 32'd1);
        cyc(); rst = 1'b0;
        cyc(); neutral(); stim.mdu_reqE = 1'b1; stim.mdu_done = 1'b1;

        // Taken branch beats load-use.
        cyc(); neutral(); stim.cnt_clr = 1'b1;
        cyc(); neutral();
        stim.wb_selE = WB_SEL_LSU; stim.rd_addrE = 5'd7; stim.rd_wr_enE = 1'b1;
        stim.rs1_addrD = 5'd7; stim.rs1_useD = 1'b1; stim.br_selE = 1'b1;
        settle();
        cmp("br_flushD", {31'd0, ifa.flushD}, 32'd1);
        cmp("br_flushE", {31'd0, ifa.flushE}, 32'd1);
        cmp("br_stallF", {31'd0, ifa.stallF}, 32'd0);
        cyc(); neutral(); settle();
        cmp("br_flush_cnt", ifa.flush_cnt, 32'd1);

        // Freeze with a pending branch.
        cyc(); neutral(); stim.cnt_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); neutral(); stim.lsu_ready = 1'b0; stim.br_selE = 1'b1; settle();
            cmp("frz_stalls", {28'd0, ifa.stallF, ifa.stallD, ifa.stallE, ifa.stallM}, 32'hF);
            cmp("frz_flushes", {29'd0, ifa.flushD, ifa.flushE, ifa.flushM}, 32'd0);
        end
        cyc(); neutral(); stim.br_selE = 1'b1; settle();
        cmp("frz_end_flushD", {31'd0, ifa.flushD}, 32'd1);
        cmp("frz_stall_cnt", ifa.stall_cnt, 32'd3);
        cmp("frz_flush_cnt0", ifa.flush_cnt, 32'd0);
        cyc(); neutral(); settle();
        cmp("frz_flush_cnt1", ifa.flush_cnt, 32'd1);

        // Interlock instance: producer of x3 in W, consumer in D.
        cyc(); neutral(); stim.cnt_clr = 1'b1;
        cyc(); neutral();
        stim.rd_addrW = 5'd3; stim.rd_wr_enW = 1'b1; stim.rs1_addrD = 5'd3; stim.rs1_useD = 1'b1;
        settle();
        cmp("ri_W_stall", {31'd0, ifb.stallF}, 32'd1);
        cmp("ri_W_bypass", {31'd0, ifa.stallF}, 32'd0);
        cyc(); neutral(); settle();
        cmp("ri_released", {31'd0, ifb.stallF}, 32'd0);
        cmp("ri_stall_cnt", {28'd0, ifb.stall_cnt}, 32'd1);

        // Saturation of the 4-bit counter.
        cyc(); neutral(); stim.cnt_clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(); neutral(); stim.lsu_ready = 1'b0;
        end
        cyc(); neutral(); settle();
        cmp("sat_cnt_B", {28'd0, ifb.stall_cnt}, 32'd15);
        cmp("sat_cnt_A", ifa.stall_cnt, 32'd20);
        cyc(); neutral(); stim.cnt_clr = 1'b1; stim.lsu_ready = 1'b0;
        cyc(); neutral(); settle();
        cmp("clr_prio", ifa.stall_cnt, 32'd0);

        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
